// File: rtl/tqvp_jnms_pdm_stereo.sv
// Stereo PDM microphone front end: PDM clock generation, 3rd-order CIC per channel,
// shift/saturate to 16-bit PCM and a small read-to-pop FIFO behind a 32-bit register file.
module tqvp_jnms_pdm_stereo #(
    parameter int FIFO_DEPTH = 8,
    parameter int ACC_W      = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] CTRL_MASK = 32'h00FF_FFF7;

    logic [31:0] ctrl_q, ctrl_d, wmask;
    logic [7:0]  half_q, half_d;
    logic [7:0]  cnt_q, dcnt_q;
    logic        pdm_q, pend_q, push_q, ovf_q, irq_q;
    logic [15:0] left_pcm_q;
    logic [5:0]  level_q;
    logic [PW-1:0] wptr_q, rptr_q;
    logic [31:0] mem_q [FIFO_DEPTH];

    logic        en, stereo, ie;
    logic [3:0]  shift_amt;
    logic [7:0]  dec, thresh, thr_eff;
    assign en        = ctrl_q[0];
    assign stereo    = ctrl_q[1];
    assign ie        = ctrl_q[2];
    assign shift_amt = ctrl_q[7:4];
    assign dec       = ctrl_q[15:8];
    assign thresh    = ctrl_q[23:16];
    assign thr_eff   = (thresh == 8'd0) ? 8'd1 : thresh;

    always_comb begin
        case (data_write_n)
            2'b00:   wmask = 32'h0000_00FF;
            2'b01:   wmask = 32'h0000_FFFF;
            2'b10:   wmask = 32'hFFFF_FFFF;
            default: wmask = 32'h0000_0000;
        endcase
    end

    always_comb begin
        ctrl_d = ctrl_q;
        half_d = half_q;
        if (address == 6'h00) ctrl_d = ((ctrl_q & ~wmask) | (data_in & wmask)) & CTRL_MASK;
        if (address == 6'h04 && wmask[0]) half_d = data_in[7:0];
    end

    // PDM clock: toggles after HALF+1 cycles; each toggle is also a sample instant.
    logic tick, smp [2], dec_evt [2];
    assign tick       = en && (cnt_q >= half_q);
    assign smp[0]     = tick && !pdm_q;
    assign smp[1]     = tick && pdm_q;
    assign dec_evt[0] = smp[0] && (dcnt_q >= dec);
    assign dec_evt[1] = smp[1] && pend_q;

    logic [ACC_W-1:0] x_val;
    assign x_val = ui_in[0] ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};

    logic [ACC_W-1:0] int1_q [2], int2_q [2], int3_q [2];
    logic [ACC_W-1:0] dly1_q [2], dly2_q [2], dly3_q [2];
    logic [ACC_W-1:0] i3n [2], c1 [2], c2 [2], c3 [2];
    logic signed [ACC_W-1:0] shifted [2];
    logic [15:0] pcm [2];

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            i3n[ch]     = int3_q[ch] + int2_q[ch];
            c1[ch]      = i3n[ch] - dly1_q[ch];
            c2[ch]      = c1[ch] - dly2_q[ch];
            c3[ch]      = c2[ch] - dly3_q[ch];
            shifted[ch] = $signed(c3[ch]) >>> shift_amt;
            // Saturate unless every bit above bit 15 matches the sign.
            if (&shifted[ch][ACC_W-1:15] || ~|shifted[ch][ACC_W-1:15])
                pcm[ch] = shifted[ch][15:0];
            else
                pcm[ch] = shifted[ch][ACC_W-1] ? 16'h8000 : 16'h7FFF;
        end
    end

    logic        push_req, push_ok, pop, empty, full, ovf_set, ovf_clr;
    logic [31:0] push_data, status;
    assign push_req  = stereo ? dec_evt[1] : dec_evt[0];
    assign push_data = stereo ? {pcm[1], left_pcm_q} : {16'h0000, pcm[0]};
    assign empty     = (level_q == 6'd0);
    assign full      = (level_q == 6'(FIFO_DEPTH));
    assign pop       = (address == 6'h0C) && (data_read_n != 2'b11) && !empty;
    assign push_ok   = push_req && (!full || pop);
    assign ovf_set   = push_req && full && !pop;
    assign ovf_clr   = (address == 6'h08) && wmask[8] && data_in[8];
    assign status    = {21'd0, full, empty, ovf_q, 2'b00, level_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= 32'h0001_3F00;
            half_q     <= 8'h0F;
            cnt_q      <= '0;
            pdm_q      <= 1'b0;
            dcnt_q     <= '0;
            pend_q     <= 1'b0;
            left_pcm_q <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                int1_q[ch] <= '0; int2_q[ch] <= '0; int3_q[ch] <= '0;
                dly1_q[ch] <= '0; dly2_q[ch] <= '0; dly3_q[ch] <= '0;
            end
        end else begin
            ctrl_q <= ctrl_d;
            half_q <= half_d;
            if (!en) begin
                cnt_q  <= '0;
                pdm_q  <= 1'b0;
                dcnt_q <= '0;
                pend_q <= 1'b0;
                for (int ch = 0; ch < 2; ch++) begin
                    int1_q[ch] <= '0; int2_q[ch] <= '0; int3_q[ch] <= '0;
                    dly1_q[ch] <= '0; dly2_q[ch] <= '0; dly3_q[ch] <= '0;
                end
            end else begin
                cnt_q <= tick ? 8'd0 : cnt_q + 8'd1;
                if (tick) pdm_q <= !pdm_q;
                if (smp[0]) dcnt_q <= dec_evt[0] ? 8'd0 : dcnt_q + 8'd1;
                if (dec_evt[0]) begin
                    pend_q     <= 1'b1;
                    left_pcm_q <= pcm[0];
                end else if (dec_evt[1]) begin
                    pend_q <= 1'b0;
                end
                for (int ch = 0; ch < 2; ch++) begin
                    if (smp[ch]) begin
                        int1_q[ch] <= int1_q[ch] + x_val;
                        int2_q[ch] <= int2_q[ch] + int1_q[ch];
                        int3_q[ch] <= i3n[ch];
                    end
                    if (dec_evt[ch]) begin
                        dly1_q[ch] <= i3n[ch];
                        dly2_q[ch] <= c1[ch];
                        dly3_q[ch] <= c2[ch];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
            push_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            level_q <= level_q + {5'd0, push_ok} - {5'd0, pop};
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            if (ovf_set)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
            push_q <= push_req;
            irq_q  <= ie && ({2'b00, level_q} >= thr_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= push_data;
    end

    always_comb begin
        case (address)
            6'h00:   data_out = ctrl_q;
            6'h04:   data_out = {24'd0, half_q};
            6'h08:   data_out = status;
            6'h0C:   data_out = empty ? 32'd0 : mem_q[rptr_q];
            default: data_out = 32'd0;
        endcase
    end

    logic unused_ok;
    assign unused_ok      = &{1'b0, ui_in[7:1]};
    assign uo_out         = {5'd0, push_q, pdm_q, 1'b0};
    assign data_ready     = 1'b1;
    assign user_interrupt = irq_q;
endmodule

// File: tb/tb_tqvp_jnms_pdm_stereo.sv
// Directed bench for tqvp_jnms_pdm_stereo: register reset values, mono/stereo DC
// decimation results, FIFO overflow, threshold interrupt and asynchronous reset.
module tb_tqvp_jnms_pdm_stereo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ui_in = 8'h01;
    logic [7:0]  uo_out;
    logic [5:0]  address = 6'h3F;
    logic [31:0] data_in = 32'd0;
    logic [1:0]  data_write_n = 2'b11;
    logic [1:0]  data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;
    logic        stereo_drv = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] rd;

    tqvp_jnms_pdm_stereo #(.FIFO_DEPTH(8), .ACC_W(25)) dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .address(address), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
        .user_interrupt(user_interrupt)
    );

    always #5 clk = ~clk;

    // PDM source: stereo pattern drives 1 while the PDM clock is low, 0 while high.
    initial begin
        forever begin
            @(negedge clk);
            ui_in = stereo_drv ? {7'd0, ~uo_out[1]} : 8'h01;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] addr, input logic [31:0] val);
        address = addr; data_in = val; data_write_n = 2'b10;
        @(posedge clk); #1;
        data_write_n = 2'b11; address = 6'h3F;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [5:0] addr, output logic [31:0] val);
        address = addr; data_read_n = 2'b00;
        #1 val = data_out;
        @(posedge clk); #1;
        data_read_n = 2'b11; address = 6'h3F;
        @(negedge clk);
    endtask

    task automatic wait_push(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (uo_out[2]) seen = 1'b1;
        end
        if (!seen) check(tag, 32'd0, 32'd1);
    endtask

    logic [31:0] mono_exp [6] = '{32'h38, 32'h188, 32'h200, 32'h200, 32'h200, 32'h200};
    logic [31:0] st_exp [6]   = '{32'hFFC80038, 32'hFE780188, 32'hFE000200,
                                  32'hFE000200, 32'hFE000200, 32'hFE000200};

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_uo", {24'd0, uo_out}, 32'd0);
        check("rst_irq", {31'd0, user_interrupt}, 32'd0);
        check("rst_ready", {31'd0, data_ready}, 32'd1);
        bus_read(6'h00, rd); check("rst_ctrl", rd, 32'h0001_3F00);
        bus_read(6'h04, rd); check("rst_clkdiv", rd, 32'h0000_000F);
        bus_read(6'h08, rd); check("rst_status", rd, 32'h0000_0200);
        bus_read(6'h0C, rd); check("rst_data_empty", rd, 32'd0);
        bus_read(6'h10, rd); check("unmapped", rd, 32'd0);

        // Mono DC: all ones, R=8 -> 8^3 = 512
        bus_write(6'h04, 32'd1);
        bus_read(6'h04, rd); check("clkdiv", rd, 32'd1);
        bus_write(6'h00, 32'h0000_0701);
        for (int k = 0; k < 6; k++) wait_push("mono_push_timeout");
        bus_write(6'h00, 32'h0000_0700);
        bus_read(6'h08, rd); check("mono_level", rd, 32'h0000_0006);
        for (int k = 0; k < 6; k++) begin
            bus_read(6'h0C, rd); check($sformatf("mono_word%0d", k), rd, mono_exp[k]);
        end

        // Stereo DC: left +512, right -512
        stereo_drv = 1'b1;
        bus_write(6'h00, 32'h0000_0703);
        for (int k = 0; k < 6; k++) wait_push("stereo_push_timeout");
        bus_write(6'h00, 32'h0000_0702);
        stereo_drv = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus_read(6'h0C, rd); check($sformatf("stereo_word%0d", k), rd, st_exp[k]);
        end
        bus_read(6'h08, rd); check("stereo_drained", rd, 32'h0000_0200);

        // Overflow: nine outputs into eight entries
        bus_write(6'h00, 32'h0000_0701);
        for (int k = 0; k < 9; k++) wait_push("ovf_push_timeout");
        bus_write(6'h00, 32'h0000_0700);
        bus_read(6'h08, rd); check("ovf_status", rd, 32'h0000_0508);
        bus_read(6'h0C, rd); check("ovf_oldest", rd, 32'h38);
        bus_read(6'h0C, rd); check("ovf_second", rd, 32'h188);
        bus_write(6'h08, 32'h0000_0100);
        bus_read(6'h08, rd); check("ovf_cleared", rd, 32'h0000_0006);
        for (int k = 0; k < 6; k++) begin
            bus_read(6'h0C, rd); check("ovf_rest", rd, 32'h200);
        end
        bus_read(6'h08, rd); check("ovf_empty", rd, 32'h0000_0200);
        bus_read(6'h0C, rd); check("empty_read", rd, 32'd0);

        // Interrupt at THRESH=2
        bus_write(6'h00, 32'h0002_0705);
        wait_push("irq_push1_timeout");
        @(negedge clk); @(negedge clk);
        check("irq_level1", {31'd0, user_interrupt}, 32'd0);
        wait_push("irq_push2_timeout");
        check("irq_not_yet", {31'd0, user_interrupt}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, user_interrupt}, 32'd1);
        bus_write(6'h00, 32'h0002_0704);
        check("irq_held", {31'd0, user_interrupt}, 32'd1);
        address = 6'h0C; data_read_n = 2'b00;
        @(posedge clk); #1;
        data_read_n = 2'b11; address = 6'h3F;
        @(negedge clk);
        check("irq_lag", {31'd0, user_interrupt}, 32'd1);
        @(negedge clk);
        check("irq_fall", {31'd0, user_interrupt}, 32'd0);

        // Asynchronous reset between clock edges
        bus_write(6'h00, 32'h0000_0701);
        wait_push("async_push_timeout");
        begin
            bit hi = 1'b0;
            for (int i = 0; i < 50 && !hi; i++) begin
                @(negedge clk);
                if (uo_out[1]) hi = 1'b1;
            end
            check("async_pdm_high", {31'd0, hi}, 32'd1);
        end
        address = 6'h08;
        #2 rst_n = 1'b0;
        #1;
        check("async_uo", {24'd0, uo_out}, 32'd0);
        check("async_status", data_out, 32'h0000_0200);
        check("async_irq", {31'd0, user_interrupt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(6'h00, rd); check("async_ctrl", rd, 32'h0001_3F00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
